nios2_onchip_memory_mm_bridge: RTL

Avalon-MM pipeline bridge placed directly upstream of the 1024x32 single-port on-chip RAM. It registers master commands, drives the RAM's chipselect/write/clken, and returns read data with an explicit readdatavalid at a fixed latency. It also contains a sequential clear engine that zero-fills or pattern-fills the whole RAM on request or after reset, holding the master off while it runs.

---
 rtl/nios2_onchip_memory_mm_bridge.sv | 137 +++++++++++++
 1 files changed

// File: rtl/nios2_onchip_memory_mm_bridge.sv
// Avalon-MM pipeline bridge in front of a single-port on-chip RAM, plus a whole-RAM clear engine.
// Latency: command reaches the RAM 1 cycle after accept; read data returns 3 cycles after accept.
// Backpressure: waitrequest only while the clear engine runs; read returns are never stalled.
module nios2_onchip_memory_mm_bridge #(
    parameter int                ADDR_W         = 10,
    parameter int                DATA_W         = 32,
    parameter bit                CLEAR_ON_RESET = 1'b0,
    parameter logic [DATA_W-1:0] CLEAR_VALUE    = '0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_W-1:0]     s_address,
    input  logic [DATA_W/8-1:0]   s_byteenable,
    input  logic                  s_read,
    input  logic                  s_write,
    input  logic [DATA_W-1:0]     s_writedata,
    output logic                  s_waitrequest,
    output logic [DATA_W-1:0]     s_readdata,
    output logic                  s_readdatavalid,
    output logic [ADDR_W-1:0]     m_address,
    output logic [DATA_W/8-1:0]   m_byteenable,
    output logic                  m_chipselect,
    output logic                  m_write,
    output logic [DATA_W-1:0]     m_writedata,
    output logic                  m_clken,
    input  logic [DATA_W-1:0]     m_readdata,
    input  logic                  clear_req,
    output logic                  clear_busy,
    output logic                  clear_done,
    output logic                  rw_err
);

    localparam int              BE_W     = DATA_W / 8;
    localparam logic [ADDR_W:0] CNT_LAST = {1'b0, {ADDR_W{1'b1}}};

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    localparam state_e ST_RESET = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;

    state_e              state_q;
    logic [ADDR_W:0]     cnt_q;
    logic [ADDR_W:0]     cnt_d;
    logic                m_cs_q;
    logic                m_wr_q;
    logic [ADDR_W-1:0]   m_addr_q;
    logic [BE_W-1:0]     m_be_q;
    logic [DATA_W-1:0]   m_wdata_q;
    logic                rd_p2_q;
    logic                rvld_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                done_q;
    logic                err_q;

    logic                accept;
    logic                clr_last;

    assign s_waitrequest = (state_q == ST_CLEAR);
    assign clear_busy    = (state_q == ST_CLEAR);
    assign accept        = (s_read | s_write) & ~s_waitrequest;
    assign clr_last      = (cnt_q == CNT_LAST);
    assign cnt_d         = clr_last ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ST_RESET;
            cnt_q     <= '0;
            m_cs_q    <= 1'b0;
            m_wr_q    <= 1'b0;
            m_addr_q  <= '0;
            m_be_q    <= '0;
            m_wdata_q <= '0;
            rd_p2_q   <= 1'b0;
            rvld_q    <= 1'b0;
            rdata_q   <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            // RAM q is valid the cycle after a read issues; capture it one cycle later still
            rd_p2_q <= m_cs_q & ~m_wr_q;
            rvld_q  <= rd_p2_q;
            if (rd_p2_q) begin
                rdata_q <= m_readdata;
            end
            done_q <= 1'b0;
            if (accept && s_read && s_write) begin
                err_q <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    m_cs_q <= accept;
                    m_wr_q <= accept & s_write;
                    if (accept) begin
                        m_addr_q  <= s_address;
                        m_be_q    <= s_byteenable;
                        m_wdata_q <= s_writedata;
                    end
                    if (clear_req) begin
                        state_q <= ST_CLEAR;
                        cnt_q   <= '0;
                    end
                end
                ST_CLEAR: begin
                    m_cs_q    <= 1'b1;
                    m_wr_q    <= 1'b1;
                    m_addr_q  <= cnt_q[ADDR_W-1:0];
                    m_be_q    <= '1;
                    m_wdata_q <= CLEAR_VALUE;
                    cnt_q     <= cnt_d;
                    // done rises together with the last clear write appearing on the RAM bus
                    if (clr_last) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign s_readdata      = rdata_q;
    assign s_readdatavalid = rvld_q;
    assign m_address       = m_addr_q;
    assign m_byteenable    = m_be_q;
    assign m_chipselect    = m_cs_q;
    assign m_write         = m_wr_q;
    assign m_writedata     = m_wdata_q;
    assign m_clken         = 1'b1;
    assign clear_done      = done_q;
    assign rw_err          = err_q;

endmodule
